// File: rtl/rr_priority_arbiter.sv
// -----------------------------------------------------------------------------
// rr_priority_arbiter
// Round-robin arbiter sharing one resource among N_REQ requesters. A rotating
// pointer marks the highest-priority index; the lowest requesting index at or
// above the pointer wins, otherwise the search wraps to the lowest requesting
// index. A grant is held until the grantee releases it, drops its request, or
// reaches MAX_HOLD consecutive cycles (0 disables the limit). Every grant is
// followed by at least one idle cycle.
//
// Ports:
//   clk_i          clock, all logic on the rising edge
//   rst_i          synchronous active-high reset
//   req_i          level-sensitive request vector, bit i = requester i
//   release_i      one-cycle pulse from the grantee ending its tenure
//   grant_o        one-hot grant (registered)
//   grant_idx_o    binary index of the grantee (registered)
//   grant_valid_o  high while a grant is held (registered)
//   timeout_o      one-cycle pulse when a grant is revoked by the hold limit
// -----------------------------------------------------------------------------
module rr_priority_arbiter #(
  parameter int N_REQ    = 16,
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_REQ-1:0] req_i,
  input  logic             release_i,
  output logic [N_REQ-1:0] grant_o,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_valid_o,
  output logic             timeout_o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e           state_q;
  logic [IDX_W-1:0] ptr_q;
  logic [CNT_W-1:0] hold_cnt_q;
  logic [N_REQ-1:0] grant_q;
  logic [IDX_W-1:0] grant_idx_q;
  logic             grant_valid_q;
  logic             timeout_q;

  logic [N_REQ-1:0] masked_req;
  logic [IDX_W-1:0] winner_d;
  logic [IDX_W-1:0] ptr_d;
  logic             end_rel;
  logic             end_drop;
  logic             end_limit;
  logic             end_any;

  // Winner selection: lowest requester at or above ptr, else lowest requester.
  always_comb begin
    masked_req = {N_REQ{1'b0}};
    winner_d   = {IDX_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (req_i[i] && (IDX_W'(i) >= ptr_q)) begin
        masked_req[i] = 1'b1;
      end else begin
        masked_req[i] = 1'b0;
      end
    end
    // Scan downward so the last hit is the lowest set index.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if ((masked_req != {N_REQ{1'b0}}) ? masked_req[i] : req_i[i]) begin
        winner_d = IDX_W'(i);
      end else begin
        winner_d = winner_d;
      end
    end
  end

  // End-of-grant conditions and the pointer value that follows the grantee.
  always_comb begin
    end_rel   = release_i;
    end_drop  = ~req_i[grant_idx_q];
    end_limit = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD));
    end_any   = end_rel | end_drop | end_limit;
    if (grant_idx_q == IDX_W'(N_REQ - 1)) begin
      ptr_d = {IDX_W{1'b0}};
    end else begin
      ptr_d = grant_idx_q + IDX_W'(1);
    end
  end

  // Arbiter FSM with registered grant outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      ptr_q         <= {IDX_W{1'b0}};
      hold_cnt_q    <= {CNT_W{1'b0}};
      grant_q       <= {N_REQ{1'b0}};
      grant_idx_q   <= {IDX_W{1'b0}};
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // release_i is ignored here; only requests start a tenure.
          if (req_i != {N_REQ{1'b0}}) begin
            state_q       <= GRANT;
            grant_q       <= N_REQ'(1'b1) << winner_d;
            grant_idx_q   <= winner_d;
            grant_valid_q <= 1'b1;
            hold_cnt_q    <= CNT_W'(1);
          end else begin
            state_q       <= IDLE;
            grant_q       <= {N_REQ{1'b0}};
            grant_idx_q   <= {IDX_W{1'b0}};
            grant_valid_q <= 1'b0;
            hold_cnt_q    <= {CNT_W{1'b0}};
          end
        end
        GRANT: begin
          if (end_any) begin
            state_q       <= IDLE;
            grant_q       <= {N_REQ{1'b0}};
            grant_idx_q   <= {IDX_W{1'b0}};
            grant_valid_q <= 1'b0;
            hold_cnt_q    <= {CNT_W{1'b0}};
            ptr_q         <= ptr_d;
            // A voluntary end (release or dropped request) masks the timeout.
            timeout_q     <= end_limit & ~end_rel & ~end_drop;
          end else begin
            hold_cnt_q    <= hold_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q       <= IDLE;
          grant_q       <= {N_REQ{1'b0}};
          grant_idx_q   <= {IDX_W{1'b0}};
          grant_valid_q <= 1'b0;
          hold_cnt_q    <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign grant_o       = grant_q;
  assign grant_idx_o   = grant_idx_q;
  assign grant_valid_o = grant_valid_q;
  assign timeout_o     = timeout_q;

endmodule
